// File: rtl/axil_to_bram_master.sv
// rtl/axil_to_bram_master.sv - AXI4-Lite subordinate issuing single accesses on a BRAM-style port
module axil_to_bram_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  // AW channel
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // W channel
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // B channel
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // AR channel
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // R channel
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // BRAM initiator port
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic [STRB_WIDTH-1:0] bram_we,
  output logic [DATA_WIDTH-1:0] bram_wrdata,
  input  logic [DATA_WIDTH-1:0] bram_rddata
);

  // Word-aligned BRAM addressing: byte-lane bits are always cleared.
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << LSB;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    BRESP = 3'd2,
    RD    = 3'd3,
    RWAIT = 3'd4,
    RRESP = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_wr_q, last_wr_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    arready_q, arready_d;
  logic                    bvalid_q, bvalid_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    en_q, en_d;
  logic [STRB_WIDTH-1:0]   we_q, we_d;
  logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;

  logic wr_cand;
  logic rd_cand;

  // AW and W are only ever taken as a pair.
  assign wr_cand = s_awvalid & s_wvalid;
  assign rd_cand = s_arvalid;

  // Next-state and registered-output logic; IDLE first raises ready, then takes the beat.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    arready_d = 1'b0;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    we_d      = we_q;
    wrdata_d  = wrdata_q;
    case (state_q)
      IDLE: begin
        if (awready_q) begin
          // Write handshake completes on this edge.
          state_d   = WR;
          en_d      = 1'b1;
          we_d      = s_wstrb;
          addr_d    = s_awaddr & ADDR_MASK;
          wrdata_d  = s_wdata;
          last_wr_d = 1'b1;
        end else if (arready_q) begin
          // Read handshake completes on this edge.
          state_d   = RD;
          en_d      = 1'b1;
          we_d      = '0;
          addr_d    = s_araddr & ADDR_MASK;
          last_wr_d = 1'b0;
        end else if (wr_cand && (!rd_cand || !last_wr_q)) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else if (rd_cand) begin
          arready_d = 1'b1;
        end
      end
      WR: begin
        state_d  = BRESP;
        we_d     = '0;
        bvalid_d = 1'b1;
      end
      BRESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD: begin
        state_d = RWAIT;
      end
      RWAIT: begin
        rdata_d  = bram_rddata;
        rvalid_d = 1'b1;
        state_d  = RRESP;
      end
      RRESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      we_q      <= '0;
      wrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      we_q      <= we_d;
      wrdata_q  <= wrdata_d;
    end
  end

  assign s_awready   = awready_q;
  assign s_wready    = wready_q;
  assign s_arready   = arready_q;
  assign s_bvalid    = bvalid_q;
  assign s_bresp     = 2'b00;
  assign s_rvalid    = rvalid_q;
  assign s_rdata     = rdata_q;
  assign s_rresp     = 2'b00;
  assign bram_addr   = addr_q;
  assign bram_en     = en_q;
  assign bram_we     = we_q;
  assign bram_wrdata = wrdata_q;

endmodule

// File: tb/tb_axil_to_bram_master.sv
// tb/tb_axil_to_bram_master.sv - directed self-checking bench for axil_to_bram_master
module tb_axil_to_bram_master;

  logic        clk;
  logic        rstn;
  logic [15:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [15:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [15:0] bram_addr;
  logic        bram_en;
  logic [7:0]  bram_we;
  logic [63:0] bram_wrdata;
  logic [63:0] bram_rddata;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          en_cnt;
  int          rv_cnt;
  logic [15:0] last_en_addr;
  logic [7:0]  last_en_we;
  logic [63:0] last_en_wd;
  logic [63:0] rd_model;
  bit          svc_q[$];

  axil_to_bram_master #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and BRAM access log (sees values of the cycle just ending).
  always @(posedge clk) begin
    cyc++;
    if (s_rvalid) rv_cnt++;
    if (bram_en) begin
      en_cnt++;
      last_en_addr = bram_addr;
      last_en_we   = bram_we;
      last_en_wd   = bram_wrdata;
      svc_q.push_back(bram_we != 8'h00);
    end
  end

  // BRAM responder: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (bram_en && bram_we == 8'h00) bram_rddata <= rd_model;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    int t_acc;
    int e0;
    bit ok;
    @(negedge clk);
    e0 = en_cnt;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_awready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("wr_accept", ok, 1);
    check("wr_wready_with_aw", s_wready, 1);
    t_acc = cyc;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_bvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("wr_bvalid", ok, 1);
    check("wr_latency", cyc - t_acc, 2);
    check("wr_bresp", s_bresp, 0);
    check("wr_en_count", en_cnt - e0, 1);
    check("wr_bram_addr", last_en_addr, a & 16'hFFF8);
    check("wr_bram_we", last_en_we, s);
    check("wr_bram_wrdata", last_en_wd, d);
    @(negedge clk);
    check("wr_bvalid_drop", s_bvalid, 0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [63:0] d, input int hold);
    int t_acc;
    int e0;
    bit ok;
    bit stable;
    @(negedge clk);
    e0 = en_cnt;
    rd_model = d;
    s_araddr = a; s_arvalid = 1'b1; s_rready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rd_accept", ok, 1);
    t_acc = cyc;
    @(negedge clk);
    s_arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_rvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rd_rvalid", ok, 1);
    check("rd_latency", cyc - t_acc, 3);
    check("rd_rdata", s_rdata, d);
    check("rd_rresp", s_rresp, 0);
    check("rd_en_count", en_cnt - e0, 1);
    check("rd_bram_addr", last_en_addr, a & 16'hFFF8);
    check("rd_bram_we", last_en_we, 0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!s_rvalid || s_rdata !== d) stable = 1'b0;
      end
      check("rd_hold_stable", stable, 1);
    end
    s_rready = 1'b1;
    @(negedge clk);
    check("rd_rvalid_drop", s_rvalid, 0);
    s_rready = 1'b0;
  endtask

  initial begin
    int rv0;
    int e0;
    int bad;
    int tmo;
    n_vec = 0; n_err = 0; cyc = 0; en_cnt = 0; rv_cnt = 0;
    rd_model = '0; bram_rddata = '0;
    rstn = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readies", {s_awready, s_wready, s_arready}, 0);
    check("rst_valids", {s_bvalid, s_rvalid, bram_en}, 0);
    check("rst_bram", {bram_addr, bram_we}, 0);
    check("rst_data", s_rdata | bram_wrdata, 0);
    rstn = 1'b1;

    // 1: reset while the read is on the BRAM port
    @(negedge clk);
    rd_model = 64'h1111_2222_3333_4444;
    s_araddr = 16'h0100; s_arvalid = 1'b1; s_rready = 1'b1;
    tmo = 1;
    for (int i = 0; i < 20; i++) begin
      if (s_arready) begin tmo = 0; break; end
      @(negedge clk);
    end
    check("t1_accept", tmo, 0);
    @(negedge clk);
    s_arvalid = 1'b0;
    check("t1_in_rd", bram_en, 1);
    rstn = 1'b0;
    #1;
    check("t1_rst_en_addr", {bram_en, bram_addr}, 0);
    check("t1_rst_valids", {s_rvalid, s_bvalid, s_arready, s_awready}, 0);
    rv0 = rv_cnt;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_no_rvalid", rv_cnt - rv0, 0);
    s_rready = 1'b0;
    rd(16'h0200, 64'h0123_4567_89AB_CDEF, 0);

    // 2: full-strobe write
    wr(16'h4000, 64'h0000_0000_1234_5678, 8'hFF);

    // 3: read with response back-pressure
    rd(16'hBFF8, 64'hDEAD_BEEF_0000_0001, 5);

    // 5: concurrent write and read streams alternate, write first
    @(negedge clk);
    svc_q.delete();
    s_bready = 1'b1; s_rready = 1'b1;
    tmo = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          bit got;
          s_awaddr = 16'h1000 + 16'(k * 8); s_wdata = 64'(k); s_wstrb = 8'hFF;
          s_awvalid = 1'b1; s_wvalid = 1'b1;
          got = 1'b0;
          for (int i = 0; i < 60; i++) begin
            if (s_awready) begin got = 1'b1; break; end
            @(negedge clk);
          end
          if (!got) tmo++;
          @(negedge clk);
          s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          bit got;
          s_araddr = 16'h2000 + 16'(k * 8); s_arvalid = 1'b1;
          got = 1'b0;
          for (int i = 0; i < 60; i++) begin
            if (s_arready) begin got = 1'b1; break; end
            @(negedge clk);
          end
          if (!got) tmo++;
          @(negedge clk);
          s_arvalid = 1'b0;
        end
      end
    join
    repeat (8) @(negedge clk);
    check("t5_timeouts", tmo, 0);
    check("t5_count", svc_q.size(), 8);
    for (int i = 0; i < 8 && i < svc_q.size(); i++) begin
      check($sformatf("t5_order_%0d", i), svc_q[i], (i % 2 == 0) ? 1 : 0);
    end
    s_rready = 1'b0;

    // 4: AW without W is never accepted on its own
    @(negedge clk);
    e0 = en_cnt;
    s_awaddr = 16'h3008; s_wdata = 64'hCAFE_F00D_0000_00AA; s_wstrb = 8'hFF;
    s_awvalid = 1'b1; s_wvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_awready || s_wready) bad++;
    end
    check("t4_no_ready", bad, 0);
    check("t4_no_en", en_cnt - e0, 0);
    wr(16'h3008, 64'hCAFE_F00D_0000_00AA, 8'hFF);

    // 6: unaligned read and single-lane write
    rd(16'h0005, 64'h5555_AAAA_5555_AAAA, 0);
    wr(16'h0010, 64'h0000_00AB_0000_0000, 8'h10);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
